// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate encoder: opcode field values,
// error codes and the NOP emitted in place of a rejected request.
// Latency: n/a. Backpressure: n/a.
package imm_pkg;

    // Instruction bits [6:2]; bits [1:0] are always 2'b11 for RV32I.
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [1:0]  OPC_LSB   = 2'b11;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_OPCODE   = 2'd3
    } err_code_e;

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of an immediate against its opcode's format.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: op_code/imm/imm_unsigned in, err_code out (0 ok, 1 range, 2 misaligned, 3 opcode).
module imm_range_check
    import imm_pkg::*;
(
    input  logic [4:0]  op_code,
    input  logic [31:0] imm,
    input  logic        imm_unsigned,
    output logic [1:0]  err_code
);

    // A value fits an N-bit signed field when every bit from N-1 up is a copy
    // of the sign, i.e. all ones or all zeros.
    logic s12_ok, u12_ok, s13_ok, s21_ok, u_low_zero;
    err_code_e code;

    assign s12_ok     = (&imm[31:11]) || !(|imm[31:11]);
    assign u12_ok     = !(|imm[31:12]);
    assign s13_ok     = (&imm[31:12]) || !(|imm[31:12]);
    assign s21_ok     = (&imm[31:20]) || !(|imm[31:20]);
    assign u_low_zero = !(|imm[11:0]);

    always_comb begin
        code = ERR_NONE;
        unique case (op_code)
            OPC_LUI, OPC_AUIPC: if (!u_low_zero) code = ERR_RANGE;
            OPC_OP_IMM, OPC_LOAD: begin
                if (imm_unsigned ? !u12_ok : !s12_ok) code = ERR_RANGE;
            end
            OPC_JALR, OPC_STORE: if (!s12_ok) code = ERR_RANGE;
            // Misalignment outranks range for the PC-relative formats.
            OPC_BRANCH: begin
                if (imm[0])       code = ERR_MISALIGN;
                else if (!s13_ok) code = ERR_RANGE;
            end
            OPC_JAL: begin
                if (imm[0])       code = ERR_MISALIGN;
                else if (!s21_ok) code = ERR_RANGE;
            end
            default: code = ERR_OPCODE;
        endcase
    end

    assign err_code = code;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: S1 latches request + range check, S2 latches encoded word.
// Latency: 2 cycles in_valid->out_valid; 1 request/cycle sustained, no bubble on simultaneous load/unload.
// Backpressure: valid/ready; out_ready=0 holds S2 stable, S1 fills, then in_ready drops.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           op_code,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [31:0]          imm,
    input  logic                 imm_unsigned,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // S1 state
    logic        s1_vld_q;
    logic [4:0]  s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [31:0] s1_imm_q;
    logic [1:0]  s1_code_q;
    logic [1:0]  s1_code_d;

    // S2 state
    logic                 s2_vld_q;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic                 s2_err_q;
    logic [1:0]           s2_code_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic s2_adv, s1_load;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign in_ready = !s1_vld_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    imm_range_check u_range_check (
        .op_code      (op_code),
        .imm          (imm),
        .imm_unsigned (imm_unsigned),
        .err_code     (s1_code_d)
    );

    // Field assembly from the S1 registers; any error collapses to a NOP.
    always_comb begin
        s2_instr_d = NOP_INSTR;
        unique case (s1_op_q)
            OPC_LUI, OPC_AUIPC:
                s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q, OPC_LSB};
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, OPC_LSB};
            OPC_STORE:
                s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:0], s1_op_q, OPC_LSB};
            OPC_BRANCH:
                s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                              s1_imm_q[4:1], s1_imm_q[11], s1_op_q, OPC_LSB};
            OPC_JAL:
                s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                              s1_rd_q, s1_op_q, OPC_LSB};
            default: s2_instr_d = NOP_INSTR;
        endcase
        if (s1_code_q != ERR_NONE) s2_instr_d = NOP_INSTR;
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_vld_q && out_ready && s2_err_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_op_q    <= '0;
            s1_f3_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_imm_q   <= '0;
            s1_code_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            s2_code_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            // S1 moves whenever it may accept; an idle input empties it.
            if (in_ready) s1_vld_q <= in_valid;
            if (s1_load) begin
                s1_op_q   <= op_code;
                s1_f3_q   <= funct3;
                s1_rd_q   <= rd;
                s1_rs1_q  <= rs1;
                s1_rs2_q  <= rs2;
                s1_imm_q  <= imm;
                s1_code_q <= s1_code_d;
            end
            // S2 data only changes on a real load, so held outputs stay put.
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_instr_q <= s2_instr_d;
                    s2_err_q   <= (s1_code_q != ERR_NONE);
                    s2_code_q  <= s1_code_q;
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign instr     = s2_instr_q;
    assign err       = s2_err_q;
    assign err_code  = s2_code_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized + directed self-checking bench for imm_encoder against a scoreboard model.
// Latency: checks 2-cycle in->out on an idle pipe. Backpressure: random out_ready, hold checks.
module tb_imm_encoder;

    localparam int CW = 4;   // narrow counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    op_code = '0;
    logic [2:0]    funct3 = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]   imm = '0;
    logic          imm_unsigned = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   instr;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] err_cnt;

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .imm_unsigned(imm_unsigned), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .err(err), .err_code(err_code),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  code;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cnt_m = 0;
    bit          lat_flag = 0;
    bit          last_acc = 0;
    bit          hold = 0;
    logic [31:0] h_instr;
    logic [2:0]  h_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: legality from signed/unsigned arithmetic ranges, fields per RV32I formats.
    function automatic exp_t model(input logic [4:0] op, input logic [2:0] f3,
                                   input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [31:0] v,
                                   input logic uns);
        exp_t   e;
        longint s;
        s = longint'($signed(v));
        e.code = 2'd0; e.acc = 0; e.lat = 0; e.instr = 32'h0;
        case (op)
            5'b01101, 5'b00101: begin
                if (v % 4096 != 0) e.code = 2'd1;
                e.instr = {v[31:12], d, op, 2'b11};
            end
            5'b00100, 5'b00000, 5'b11001: begin
                if (uns && op != 5'b11001) begin
                    if (v > 32'd4095) e.code = 2'd1;
                end else if (s < -2048 || s > 2047) e.code = 2'd1;
                e.instr = {v[11:0], s1, f3, d, op, 2'b11};
            end
            5'b01000: begin
                if (s < -2048 || s > 2047) e.code = 2'd1;
                e.instr = {v[11:5], s2, s1, f3, v[4:0], op, 2'b11};
            end
            5'b11000: begin
                if (v[0]) e.code = 2'd2;
                else if (s < -4096 || s > 4095) e.code = 2'd1;
                e.instr = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op, 2'b11};
            end
            5'b11011: begin
                if (v[0]) e.code = 2'd2;
                else if (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 1) e.code = 2'd1;
                e.instr = {v[20], v[10:1], v[11], v[19:12], d, op, 2'b11};
            end
            default: e.code = 2'd3;
        endcase
        if (e.code != 2'd0) e.instr = 32'h0000_0013;
        return e;
    endfunction

    // One clock: observe transfers at the negedge, then advance to #1 after posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_acc = 0;
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            hold = 0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
                check_eq("hold_instr", instr, h_instr);
                check_eq("hold_err", {29'd0, err, err_code}, {29'd0, h_err});
            end
            hold = out_valid && !out_ready;
            h_instr = instr;
            h_err = {err, err_code};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("instr", instr, e.instr);
                    check_eq("err", {31'd0, err}, {31'd0, e.code != 2'd0});
                    check_eq("err_code", {30'd0, err_code}, {30'd0, e.code});
                    check_eq("err_cnt", {28'd0, err_cnt}, cnt_m);
                    if (e.lat) check_eq("latency", cyc - e.acc, 2);
                    if (e.code != 2'd0 && cnt_m < (1 << CW) - 1) cnt_m++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(op_code, funct3, rd, rs1, rs2, imm, imm_unsigned);
                e.acc = cyc;
                e.lat = lat_flag;
                q.push_back(e);
                last_acc = 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] v,
                           input logic uns);
        op_code = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = v; imm_unsigned = uns;
        in_valid = 1'b1;
    endtask

    // Offer one request until accepted (bounded), then deassert valid.
    task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] v,
                        input logic uns);
        int n = 0;
        set_req(op, f3, d, s1, s2, v, uns);
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 40);
        check_eq("accept_timeout", {31'd0, last_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        cycle();
        check_eq("drain_timeout", q.size(), 0);
    endtask

    task automatic rand_req();
        logic [31:0] bnd [16];
        logic [4:0]  ops [8];
        logic [4:0]  op;
        logic [31:0] v;
        bnd = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4095, 32'd4096,
                -32'd4096, -32'd4097, 32'd1048574, 32'd1048576, -32'd1048576,
                -32'd1048578, 32'd3, 32'd8, 32'h1234_5000, 32'h0000_0800};
        ops = '{5'b01101, 5'b00101, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
                5'b11000, 5'b11011};
        op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       v = $urandom & 32'hFFFF_F000;
            default: v = bnd[$urandom_range(0, 15)];
        endcase
        set_req(op, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v,
                1'($urandom));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_err", {29'd0, err, err_code}, 32'd0);
        check_eq("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors with latency check on an idle pipe
        lat_flag = 1;
        send(5'b00100, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        drain();
        send(5'b11000, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        drain();
        check_eq("err_cnt_pre", {28'd0, err_cnt}, 32'd0);
        send(5'b11011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
        drain();
        check_eq("err_cnt_jal", {28'd0, err_cnt}, 32'd1);
        send(5'b01000, 3'd2, 5'd0, 5'd3, 5'd4, 32'd2048, 1'b0);
        drain();
        lat_flag = 0;

        // Stall: 3 back-to-back requests under 5 cycles of out_ready=0
        out_ready = 1'b0;
        set_req(5'b00100, 3'd1, 5'd5, 5'd6, 5'd0, 32'd7, 1'b0);
        cycle();
        set_req(5'b01101, 3'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_E000, 1'b0);
        cycle();
        set_req(5'b11011, 3'd0, 5'd9, 5'd0, 5'd0, 32'd2048, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            cycle();
        end
        check_eq("stall_accepted", q.size(), 2);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!last_acc && n < 20) begin
                cycle();
                n++;
            end
        end
        in_valid = 1'b0;
        check_eq("stall_all_in", q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && $urandom_range(0, 9) < 7) rand_req();
            cycle();
            if (last_acc) in_valid = 1'b0;
        end
        drain();

        // Saturation: push enough errors to pin the counter at all-ones
        for (int i = 0; i < (1 << CW) + 2; i++) send(5'b11111, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        drain();
        check_eq("err_cnt_sat", {28'd0, err_cnt}, 32'hF);

        // Reset with both stages full discards everything
        out_ready = 1'b0;
        set_req(5'b00100, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
        cycle();
        set_req(5'b00111, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        check_eq("full_before_rst", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("post_rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 op_code  input  5  instruction bits [6:2]; bits [1:0] are always 2'b11.
REQ-007 funct3  input  3  funct3 field.
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 imm  input  32  immediate value; LUI/AUIPC carry the already-shifted upper value.
REQ-010 imm_unsigned  input  1  range-check I/LOAD immediates as unsigned 12-bit.
REQ-011 out_valid  output  1  encoded instruction valid.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 instr  output  32  encoded RV32I instruction.
REQ-014 err  output  1  request was rejected; qualified by out_valid.
REQ-015 err_code  output  2  0 none, 1 range, 2 misaligned, 3 unsupported opcode.
REQ-016 err_cnt  output  ERR_CNT_W  count of rejected requests.

Function
REQ-017 Transfers occur on valid&&ready at each port; requests are never dropped, duplicated, or reordered.
REQ-018 Two-stage pipeline: S1 registers the inputs and the range-check result, S2 registers the assembled instr/err/err_code; latency in_valid->out_valid is exactly 2 cycles with out_ready held high.
REQ-019 Each stage advances when it is empty or its successor advances; in_ready = !S1_valid || S1_advance; full throughput is 1 request/cycle.
REQ-020 While out_valid=1 and out_ready=0, instr/err/err_code SHALL hold stable.
REQ-021 Encodings: LUI 01101 / AUIPC 00101 U-type imm[31:12]; OP-IMM 00100, LOAD 00000, JALR 11001 I-type imm[11:0]; STORE 01000 S-type; BRANCH 11000 B-type; JAL 11011 J-type.
REQ-022 Range: I/S/JALR signed -2048..2047, or 0..4095 for OP-IMM/LOAD when imm_unsigned=1; B signed 13-bit; J signed 21-bit; U requires imm[11:0]=0.
REQ-023 Misaligned: B or J with imm[0]=1 gives err_code 2; misalignment takes priority over range.
REQ-024 An opcode outside REQ-021 gives err_code 3.
REQ-025 On any error: instr=32'h0000_0013 (NOP) and err=1; otherwise err=0, err_code=0.
REQ-026 Unused fields for a format (e.g. rd for S/B, rs2 for I) are ignored, not checked.
REQ-027 err_cnt increments by 1 on each output transfer with err=1 and saturates at all-ones.
REQ-028 A simultaneous S2 output transfer and S1 load in the same cycle is supported with no bubble.

Reset
REQ-029 With rst_n=0 at a clock edge: S1/S2 valid=0, out_valid=0, instr=0, err=0, err_code=0, err_cnt=0.
REQ-030 Reset mid-operation discards all in-flight requests; in_ready=1 in the first cycle after rst_n returns high.

Structure
REQ-031 Shared package imm_pkg holds the opcode constants, the err_code enum, and NOP_INSTR.
REQ-032 Combinational sub-module imm_range_check (op_code, imm, imm_unsigned -> err_code) is instantiated in S1.

Verification
REQ-033 OP-IMM, rd=1, rs1=0, funct3=0, imm=32'hFFFF_FFFF -> instr 32'hFFF0_0093, err=0, two cycles after acceptance.
REQ-034 BRANCH, funct3=0, rs1=1, rs2=2, imm=8 -> instr 32'h0020_8463.
REQ-035 JAL imm=3 -> err=1, err_code=2, instr 32'h0000_0013, err_cnt 0->1; STORE imm=2048 -> err_code=1.
REQ-036 out_ready=0 for 5 cycles with 3 back-to-back requests -> 2 are accepted, in_ready=0, the outputs are held stable, and all 3 emerge in order once out_ready=1.
REQ-037 rst_n=0 with both stages full -> no out_valid after reset, err_cnt=0; err_cnt preset near max with 2 errors -> saturates at all-ones.
